dec_entry: RTL and testbench

- Sequential decimal-to-binary operand entry for the four-function calculator datapath: the input-direction counterpart of the binary-to-7-segment decimal display path.
- Accepts decimal digit keystrokes, sign toggle and clear.
- Accumulates a signed W-bit binary operand with a multi-cycle ×10-and-add FSM.
- Exports a BCD echo of the entered digits so the 7-segment display can show the entry as it is typed.

---
 rtl/dec_entry_pkg.sv | 21 ++
 rtl/dec_entry_if.sv | 34 +++
 rtl/dec_entry_key_edge.sv | 22 ++
 rtl/dec_entry.sv | 210 +++++++++++++++++++++
 tb/tb_dec_entry.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_entry_pkg.sv
// Shared types and constants for the decimal operand-entry path of the calculator.
// Imported by dec_entry_if, key_edge and dec_entry.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      ADD,
      RECALC
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam int unsigned TEN = 10;

   // Largest magnitude representable by a signed w-bit result.
   function automatic int unsigned limit(input int unsigned w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/dec_entry_if.sv
// Keypad-side inputs and display/datapath-side outputs of dec_entry.
// The master modport drives the keys; the slave modport is the entry block.
interface dec_entry_if #(
   parameter int unsigned W    = 11,
   parameter int unsigned NDIG = 3
);
   import calc_pkg::*;

   localparam int unsigned CW = $clog2(NDIG + 1);

   logic              DigitKey;
   bcd_t              Digit;
   logic              NegKey;
   logic              ClrKey;
   logic              BkspKey;
   logic [W-1:0]      Value;
   logic [4*NDIG-1:0] Bcd;
   logic              Neg;
   logic [CW-1:0]     Count;
   logic              Busy;
   logic              Overflow;
   logic              Invalid;

   modport master (
      output DigitKey, Digit, NegKey, ClrKey, BkspKey,
      input  Value, Bcd, Neg, Count, Busy, Overflow, Invalid
   );

   modport slave (
      input  DigitKey, Digit, NegKey, ClrKey, BkspKey,
      output Value, Bcd, Neg, Count, Busy, Overflow, Invalid
   );

endinterface

// File: rtl/dec_entry_key_edge.sv
// Rising-edge detector for one keypad line: o_rise is high in the first cycle
// the level is seen high, so a held key yields a single event.
module key_edge (
   input  logic Clock,
   input  logic Resetn,
   input  logic i_level,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_level;
      end
   end

   assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/dec_entry.sv
// Sequential decimal-to-binary operand entry with BCD echo for the display.
// Define DEC_ENTRY_BKSP_EN to build the backspace key and its RECALC state.
module dec_entry
   import calc_pkg::*;
#(
   parameter int unsigned W    = 11,
   parameter int unsigned NDIG = 3
) (
   input  logic         Clock,
   input  logic         Resetn,
   dec_entry_if.slave   bus
);

   localparam int unsigned CW = $clog2(NDIG + 1);
   localparam int unsigned XW = W + 4;
   localparam int unsigned BW = 4 * NDIG;
   localparam logic [XW-1:0] LIMIT_X = XW'(limit(W));

   logic w_dig_ev;
   logic w_neg_ev;
   logic w_clr_ev;

   state_t          r_state;
   state_t          w_state_nx;
   logic [W-1:0]    r_acc;
   logic [W-1:0]    w_acc_nx;
   logic [XW-1:0]   r_prod;
   logic [XW-1:0]   w_prod_nx;
   bcd_t            r_digit;
   bcd_t            w_digit_nx;
   logic [BW-1:0]   r_bcd;
   logic [BW-1:0]   w_bcd_nx;
   logic            r_neg;
   logic            w_neg_nx;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nx;
   logic            r_ovf;
   logic            w_ovf_nx;
   logic            r_inv;
   logic            w_inv_nx;

   logic [XW-1:0]   w_acc_x;
   logic [XW-1:0]   w_sum;
   logic            w_lead_zero;

   key_edge u_dig_edge (.Clock(Clock), .Resetn(Resetn), .i_level(bus.DigitKey), .o_rise(w_dig_ev));
   key_edge u_neg_edge (.Clock(Clock), .Resetn(Resetn), .i_level(bus.NegKey),   .o_rise(w_neg_ev));
   key_edge u_clr_edge (.Clock(Clock), .Resetn(Resetn), .i_level(bus.ClrKey),   .o_rise(w_clr_ev));

`ifdef DEC_ENTRY_BKSP_EN
   logic            w_bksp_ev;
   logic [CW-1:0]   r_iter;
   logic [CW-1:0]   w_iter_nx;
   bcd_t            w_nib;
   logic [XW-1:0]   w_rec;

   key_edge u_bksp_edge (.Clock(Clock), .Resetn(Resetn), .i_level(bus.BkspKey), .o_rise(w_bksp_ev));

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_iter <= '0;
      end else begin
         r_iter <= w_iter_nx;
      end
   end
`else
   logic w_unused_bksp;
   assign w_unused_bksp = bus.BkspKey;
`endif

   assign w_acc_x     = XW'(r_acc);
   assign w_sum       = r_prod + XW'(r_digit);
   assign w_lead_zero = (bus.Digit == 4'd0) && (r_count == '0);

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_acc   <= '0;
         r_prod  <= '0;
         r_digit <= '0;
         r_bcd   <= '0;
         r_neg   <= 1'b0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_inv   <= 1'b0;
      end else begin
         r_acc   <= w_acc_nx;
         r_prod  <= w_prod_nx;
         r_digit <= w_digit_nx;
         r_bcd   <= w_bcd_nx;
         r_neg   <= w_neg_nx;
         r_count <= w_count_nx;
         r_ovf   <= w_ovf_nx;
         r_inv   <= w_inv_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_acc_nx   = r_acc;
      w_prod_nx  = r_prod;
      w_digit_nx = r_digit;
      w_bcd_nx   = r_bcd;
      w_neg_nx   = r_neg;
      w_count_nx = r_count;
      w_ovf_nx   = r_ovf;
      w_inv_nx   = 1'b0;
`ifdef DEC_ENTRY_BKSP_EN
      w_iter_nx  = r_iter;
      w_nib      = bcd_t'(r_bcd >> (4 * (NDIG - 1 - 32'(r_iter))));
      w_rec      = (w_acc_x << 3) + (w_acc_x << 1) + XW'(w_nib);
`endif

      // Clear beats every other event and aborts any multi-cycle operation.
      if (w_clr_ev) begin
         w_state_nx = IDLE;
         w_acc_nx   = '0;
         w_bcd_nx   = '0;
         w_neg_nx   = 1'b0;
         w_count_nx = '0;
         w_ovf_nx   = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
`ifdef DEC_ENTRY_BKSP_EN
               if (w_bksp_ev) begin
                  if (r_count == '0) begin
                     w_inv_nx = 1'b1;
                  end else begin
                     w_bcd_nx   = r_bcd >> 4;
                     w_count_nx = r_count - 1'b1;
                     w_acc_nx   = '0;
                     w_iter_nx  = '0;
                     w_state_nx = RECALC;
                  end
               end else
`endif
               if (w_neg_ev) begin
                  if (r_acc != '0) begin
                     w_neg_nx = ~r_neg;
                  end
               end else if (w_dig_ev) begin
                  if (32'(bus.Digit) >= TEN) begin
                     w_inv_nx = 1'b1;
                  end else if (!w_lead_zero) begin
                     if (r_count == CW'(NDIG)) begin
                        w_inv_nx = 1'b1;
                     end else begin
                        w_digit_nx = bus.Digit;
                        w_state_nx = MUL;
                     end
                  end
               end
            end

            MUL: begin
               w_prod_nx  = (w_acc_x << 3) + (w_acc_x << 1);
               w_state_nx = ADD;
            end

            ADD: begin
               if (w_sum > LIMIT_X) begin
                  w_ovf_nx = 1'b1;
                  w_inv_nx = 1'b1;
               end else begin
                  w_acc_nx   = W'(w_sum);
                  w_bcd_nx   = (r_bcd << 4) | BW'(r_digit);
                  w_count_nx = r_count + 1'b1;
               end
               w_state_nx = IDLE;
            end

            RECALC: begin
`ifdef DEC_ENTRY_BKSP_EN
               // Rebuild the binary value from the shortened BCD echo, MSD first.
               w_acc_nx = W'(w_rec);
               if (r_iter == CW'(NDIG - 1)) begin
                  w_state_nx = IDLE;
                  if (w_rec == '0) begin
                     w_neg_nx = 1'b0;
                  end
               end else begin
                  w_iter_nx = r_iter + 1'b1;
               end
`else
               w_state_nx = IDLE;
`endif
            end

            default: w_state_nx = IDLE;
         endcase
      end
   end

   assign bus.Value    = r_neg ? ('0 - r_acc) : r_acc;
   assign bus.Bcd      = r_bcd;
   assign bus.Neg      = r_neg;
   assign bus.Count    = r_count;
   assign bus.Busy     = (r_state != IDLE);
   assign bus.Overflow = r_ovf;
   assign bus.Invalid  = r_inv;

endmodule

// File: tb/tb_dec_entry.sv
// Self-checking bench for dec_entry: W=11 and W=8 instances driven by the same keys,
// checked against a decimal-number reference model (DEC_ENTRY_BKSP_EN aware).
module tb_dec_entry;
   import calc_pkg::*;

   localparam int unsigned NDIG = 3;
   localparam int unsigned WA   = 11;
   localparam int unsigned WB   = 8;

   localparam int K_DIG  = 1;
   localparam int K_NEG  = 2;
   localparam int K_CLR  = 4;
   localparam int K_BKSP = 8;

   logic Clock  = 1'b0;
   logic Resetn = 1'b0;
   always #5 Clock = ~Clock;

   dec_entry_if #(.W(WA), .NDIG(NDIG)) bus_a ();
   dec_entry_if #(.W(WB), .NDIG(NDIG)) bus_b ();

   dec_entry #(.W(WA), .NDIG(NDIG)) dut_a (.Clock(Clock), .Resetn(Resetn), .bus(bus_a));
   dec_entry #(.W(WB), .NDIG(NDIG)) dut_b (.Clock(Clock), .Resetn(Resetn), .bus(bus_b));

   int total = 0;
   int bad   = 0;

   // Reference state: the entered operand as a plain decimal number per instance.
   int m_v[2];
   bit m_neg[2];
   bit m_ovf[2];
   int lim[2] = '{1023, 127};
   int wid[2] = '{11, 8};

   typedef struct {
      int mask;
      int d;
      int hold;
      int val;
      int bcd;
      int cnt;
      int neg;
      int inv;
   } vec_t;

   vec_t tbl[$];

   function automatic int ndig(input int v);
      int n = 0;
      while (v > 0) begin
         n++;
         v = v / 10;
      end
      return n;
   endfunction

   function automatic int to_bcd(input int v);
      int r = 0;
      int sh = 0;
      while (v > 0) begin
         r = r | ((v % 10) << sh);
         sh += 4;
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int pat(input int v, input bit n, input int w);
      return n ? ((1 << w) - v) : v;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_v[i]   = 0;
         m_neg[i] = 1'b0;
         m_ovf[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int i, input int mask, input int d,
                             output int inv, output int busy, output int lat);
      inv  = 0;
      busy = 0;
      lat  = 0;
      if ((mask & K_CLR) != 0) begin
         m_v[i]   = 0;
         m_neg[i] = 1'b0;
         m_ovf[i] = 1'b0;
      end
`ifdef DEC_ENTRY_BKSP_EN
      else if ((mask & K_BKSP) != 0) begin
         if (m_v[i] == 0) begin
            inv = 1;
         end else begin
            m_v[i] = m_v[i] / 10;
            busy   = NDIG;
            if (m_v[i] == 0) m_neg[i] = 1'b0;
         end
      end
`endif
      else if ((mask & K_NEG) != 0) begin
         if (m_v[i] != 0) m_neg[i] = !m_neg[i];
      end else if ((mask & K_DIG) != 0) begin
         if (d > 9) begin
            inv = 1;
         end else if (!(d == 0 && m_v[i] == 0)) begin
            if (ndig(m_v[i]) == NDIG) begin
               inv = 1;
            end else begin
               busy = 2;
               if (m_v[i] * 10 + d > lim[i]) begin
                  m_ovf[i] = 1'b1;
                  inv      = 1;
               end else begin
                  m_v[i] = m_v[i] * 10 + d;
                  lat    = 3;
               end
            end
         end
      end
   endtask

   task automatic check_outs(input int i, input string tag, input int val, input int bcd,
                             input int cnt, input int neg, input int ovf);
      chk($sformatf("%s dut%0d value", tag, i), val, pat(m_v[i], m_neg[i], wid[i]));
      chk($sformatf("%s dut%0d bcd", tag, i), bcd, to_bcd(m_v[i]));
      chk($sformatf("%s dut%0d count", tag, i), cnt, ndig(m_v[i]));
      chk($sformatf("%s dut%0d neg", tag, i), neg, int'(m_neg[i]));
      chk($sformatf("%s dut%0d ovf", tag, i), ovf, int'(m_ovf[i]));
   endtask

   task automatic set_keys(input int mask, input int d);
      bus_a.DigitKey = (mask & K_DIG) != 0;
      bus_a.NegKey   = (mask & K_NEG) != 0;
      bus_a.ClrKey   = (mask & K_CLR) != 0;
      bus_a.BkspKey  = (mask & K_BKSP) != 0;
      bus_a.Digit    = 4'(d);
      bus_b.DigitKey = (mask & K_DIG) != 0;
      bus_b.NegKey   = (mask & K_NEG) != 0;
      bus_b.ClrKey   = (mask & K_CLR) != 0;
      bus_b.BkspKey  = (mask & K_BKSP) != 0;
      bus_b.Digit    = 4'(d);
   endtask

   // Called at a negedge; returns at a negedge with keys released and both DUTs idle.
   task automatic press(input int mask, input int d, input int hold, input string tag,
                        output int inv_a, output int inv_b);
      int inv_e[2];
      int busy_e[2];
      int lat_e[2];
      int inv_c[2];
      int busy_c[2];
      int lat_c[2];
      for (int i = 0; i < 2; i++) begin
         model_step(i, mask, d, inv_e[i], busy_e[i], lat_e[i]);
         inv_c[i]  = 0;
         busy_c[i] = 0;
         lat_c[i]  = 0;
      end
      set_keys(mask, d);
      for (int c = 0; c < hold + 8; c++) begin
         @(negedge Clock);
         if (bus_a.Invalid) inv_c[0]++;
         if (bus_b.Invalid) inv_c[1]++;
         if (bus_a.Busy) busy_c[0]++;
         if (bus_b.Busy) busy_c[1]++;
         if (lat_c[0] == 0 && int'(bus_a.Count) == ndig(m_v[0])) lat_c[0] = c + 1;
         if (lat_c[1] == 0 && int'(bus_b.Count) == ndig(m_v[1])) lat_c[1] = c + 1;
         if (c == hold - 1) set_keys(0, 0);
      end
      check_outs(0, tag, int'(bus_a.Value), int'(bus_a.Bcd), int'(bus_a.Count),
                 int'(bus_a.Neg), int'(bus_a.Overflow));
      check_outs(1, tag, int'(bus_b.Value), int'(bus_b.Bcd), int'(bus_b.Count),
                 int'(bus_b.Neg), int'(bus_b.Overflow));
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s dut%0d invalid_cycles", tag, i), inv_c[i], inv_e[i]);
         chk($sformatf("%s dut%0d busy_cycles", tag, i), busy_c[i], busy_e[i]);
         if (lat_e[i] != 0) chk($sformatf("%s dut%0d latency", tag, i), lat_c[i], lat_e[i]);
      end
      inv_a = inv_c[0];
      inv_b = inv_c[1];
   endtask

   task automatic add(input int mask, input int d, input int hold, input int val,
                      input int bcd, input int cnt, input int neg, input int inv);
      vec_t v;
      v.mask = mask; v.d = d; v.hold = hold; v.val = val;
      v.bcd = bcd; v.cnt = cnt; v.neg = neg; v.inv = inv;
      tbl.push_back(v);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " a value"}, int'(bus_a.Value), 0);
      chk({tag, " a bcd"}, int'(bus_a.Bcd), 0);
      chk({tag, " a count"}, int'(bus_a.Count), 0);
      chk({tag, " a neg"}, int'(bus_a.Neg), 0);
      chk({tag, " a busy"}, int'(bus_a.Busy), 0);
      chk({tag, " a ovf"}, int'(bus_a.Overflow), 0);
      chk({tag, " a invalid"}, int'(bus_a.Invalid), 0);
      chk({tag, " b value"}, int'(bus_b.Value), 0);
      chk({tag, " b count"}, int'(bus_b.Count), 0);
      chk({tag, " b busy"}, int'(bus_b.Busy), 0);
      chk({tag, " b ovf"}, int'(bus_b.Overflow), 0);
   endtask

   initial begin
      int ia;
      int ib;
      int seen_inv;
      set_keys(0, 0);
      model_reset();

      // Table for the W=11 instance: expected Value is the 11-bit two's-complement pattern.
      add(K_DIG, 1, 1, 1, 'h1, 1, 0, 0);
      add(K_DIG, 2, 1, 12, 'h12, 2, 0, 0);
      add(K_DIG, 3, 1, 123, 'h123, 3, 0, 0);
      add(K_DIG, 5, 1, 123, 'h123, 3, 0, 1);
      add(K_CLR, 0, 1, 0, 0, 0, 0, 0);
      add(K_DIG, 9, 1, 9, 'h9, 1, 0, 0);
      add(K_DIG, 9, 1, 99, 'h99, 2, 0, 0);
      add(K_DIG, 9, 1, 999, 'h999, 3, 0, 0);
      add(K_DIG, 5, 1, 999, 'h999, 3, 0, 1);
      add(K_CLR, 0, 1, 0, 0, 0, 0, 0);
      add(K_DIG, 0, 1, 0, 0, 0, 0, 0);
      add(K_DIG, 0, 1, 0, 0, 0, 0, 0);
      add(K_DIG, 7, 1, 7, 'h7, 1, 0, 0);
      add(K_CLR, 0, 1, 0, 0, 0, 0, 0);
      add(K_NEG, 0, 1, 0, 0, 0, 0, 0);
      add(K_DIG, 4, 1, 4, 'h4, 1, 0, 0);
      add(K_DIG, 5, 1, 45, 'h45, 2, 0, 0);
      add(K_NEG, 0, 1, 'h7D3, 'h45, 2, 1, 0);
      add(K_DIG, 12, 1, 'h7D3, 'h45, 2, 1, 1);
      add(K_DIG | K_CLR, 6, 1, 0, 0, 0, 0, 0);
      add(K_DIG, 8, 5, 8, 'h8, 1, 0, 0);
      add(K_NEG, 0, 1, 2040, 'h8, 1, 1, 0);
      add(K_NEG, 0, 1, 8, 'h8, 1, 0, 0);
      add(K_DIG | K_NEG, 3, 1, 2040, 'h8, 1, 1, 0);
      add(K_CLR, 0, 1, 0, 0, 0, 0, 0);
`ifdef DEC_ENTRY_BKSP_EN
      add(K_DIG, 6, 1, 6, 'h6, 1, 0, 0);
      add(K_DIG, 7, 1, 67, 'h67, 2, 0, 0);
      add(K_DIG, 8, 1, 678, 'h678, 3, 0, 0);
      add(K_BKSP, 0, 1, 67, 'h067, 2, 0, 0);
      add(K_CLR, 0, 1, 0, 0, 0, 0, 0);
      add(K_BKSP, 0, 1, 0, 0, 0, 0, 1);
`else
      add(K_BKSP, 0, 1, 0, 0, 0, 0, 0);
      add(K_BKSP | K_DIG, 2, 1, 2, 'h2, 1, 0, 0);
      add(K_CLR, 0, 1, 0, 0, 0, 0, 0);
`endif

      repeat (2) @(negedge Clock);
      check_all_zero("reset");
      Resetn = 1'b1;
      @(negedge Clock);

      foreach (tbl[n]) begin
         press(tbl[n].mask, tbl[n].d, tbl[n].hold, $sformatf("vec%0d", n), ia, ib);
         chk($sformatf("tbl%0d value", n), int'(bus_a.Value), tbl[n].val);
         chk($sformatf("tbl%0d bcd", n), int'(bus_a.Bcd), tbl[n].bcd);
         chk($sformatf("tbl%0d count", n), int'(bus_a.Count), tbl[n].cnt);
         chk($sformatf("tbl%0d neg", n), int'(bus_a.Neg), tbl[n].neg);
         chk($sformatf("tbl%0d invalid", n), ia, tbl[n].inv);
      end

      // W=8 limit: 128 is out of range, so the third digit is rejected.
      press(K_CLR, 0, 1, "w8clr", ia, ib);
      press(K_DIG, 1, 1, "w8d1", ia, ib);
      press(K_DIG, 2, 1, "w8d2", ia, ib);
      press(K_DIG, 8, 1, "w8d8", ia, ib);
      chk("w8 value", int'(bus_b.Value), 12);
      chk("w8 overflow", int'(bus_b.Overflow), 1);
      chk("w8 invalid", ib, 1);
      chk("w11 value 128", int'(bus_a.Value), 128);

      // Clear during MUL aborts the pending digit.
      press(K_CLR, 0, 1, "mclr0", ia, ib);
      press(K_DIG, 4, 1, "mclr1", ia, ib);
      set_keys(K_DIG, 3);
      @(negedge Clock);
      chk("clr_in_mul busy", int'(bus_a.Busy), 1);
      set_keys(K_CLR, 0);
      @(negedge Clock);
      set_keys(0, 0);
      model_reset();
      check_all_zero("clr_in_mul");
      repeat (4) @(negedge Clock);
      check_all_zero("clr_in_mul later");

      // Digit event during ADD is dropped without an Invalid pulse.
      seen_inv = 0;
      set_keys(K_DIG, 2);
      @(negedge Clock);
      set_keys(0, 0);
      @(negedge Clock);
      chk("drop busy", int'(bus_a.Busy), 1);
      set_keys(K_DIG, 9);
      for (int c = 0; c < 6; c++) begin
         @(negedge Clock);
         if (bus_a.Invalid) seen_inv++;
         if (c == 0) set_keys(0, 0);
      end
      chk("drop value", int'(bus_a.Value), 2);
      chk("drop count", int'(bus_a.Count), 1);
      chk("drop invalid", seen_inv, 0);
      chk("drop w8 value", int'(bus_b.Value), 2);
      m_v[0] = 2;
      m_v[1] = 2;

      // Reset in the middle of an entry wins over the FSM.
      set_keys(K_DIG, 7);
      @(negedge Clock);
      set_keys(0, 0);
      Resetn = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;
      model_reset();
      check_all_zero("reset_mid");
      repeat (3) @(negedge Clock);
      check_all_zero("reset_mid later");

      // Random keystrokes, including coincident keys, against the reference model.
      for (int n = 0; n < 250; n++) begin
         int r;
         int mask;
         r = $urandom_range(0, 99);
         if (r < 55)      mask = K_DIG;
         else if (r < 67) mask = K_NEG;
         else if (r < 74) mask = K_CLR;
         else if (r < 86) mask = K_BKSP;
         else             mask = $urandom_range(1, 15);
         press(mask, $urandom_range(0, 11), $urandom_range(1, 3), $sformatf("rnd%0d", n), ia, ib);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
